// File: rtl/spi_slave.sv
// Byte-wide SPI peripheral that oversamples sclk/mosi/ss_n in the clk domain.
// Supports all four CPOL/CPHA modes and uses a one-deep TX holding buffer.
module spi_slave #(
  parameter int                SYNC_STAGES = 2,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] IDLE_FILL   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              ss_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              underrun
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_s, mosi_s, ss_s, sclk_prev, ss_prev;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   ss_fall, ss_rise;
  logic [CW-1:0]          bit_cnt, bit_cnt_n;
  logic                   word_done, word_done_n;
  logic [DATA_W-1:0]      tx_shift, tx_shift_n, rx_shift, rx_shift_n;
  logic [DATA_W-1:0]      rx_data_n, buf_data, buf_data_n;
  logic                   buf_full, buf_full_n;
  logic                   rx_valid_n, miso_n, miso_oe_n, underrun_n;
  logic                   consume, use_fill;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead_edge   = (sclk_s != sclk_prev) && (sclk_s != cpol);
  assign trail_edge  = (sclk_s != sclk_prev) && (sclk_s == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge  : trail_edge;
  assign ss_fall     = ss_prev & ~ss_s;
  assign ss_rise     = ~ss_prev & ss_s;

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    word_done_n = word_done;
    tx_shift_n  = tx_shift;
    rx_shift_n  = rx_shift;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    miso_oe_n   = miso_oe;
    buf_data_n  = buf_data;
    buf_full_n  = buf_full;
    underrun_n  = underrun;
    consume     = 1'b0;
    use_fill    = 1'b0;

    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          state_n     = ACTIVE;
          tx_shift_n  = buf_full ? buf_data : IDLE_FILL;
          consume     = buf_full;
          use_fill    = ~buf_full;
          bit_cnt_n   = '0;
          word_done_n = 1'b0;
          miso_oe_n   = 1'b1;
        end
      end
      ACTIVE: begin
        // A full count is retired one cycle after the last sample edge.
        if (bit_cnt == CW'(DATA_W)) begin
          rx_data_n   = rx_shift;
          rx_valid_n  = 1'b1;
          bit_cnt_n   = '0;
          word_done_n = 1'b1;
        end else if (sample_edge) begin
          rx_shift_n = {rx_shift[DATA_W-2:0], mosi_s};
          bit_cnt_n  = bit_cnt + CW'(1);
        end
        if (shift_edge && !ss_rise) begin
          if (bit_cnt != '0) begin
            tx_shift_n = tx_shift << 1;
          end else if (word_done) begin
            tx_shift_n  = buf_full ? buf_data : IDLE_FILL;
            consume     = buf_full;
            use_fill    = ~buf_full;
            word_done_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (ss_rise) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      word_done_n = 1'b0;
      miso_oe_n   = 1'b0;
    end

    if (consume) buf_full_n = 1'b0;
    if (tx_load) begin
      underrun_n = 1'b0;
      if (!buf_full) begin
        buf_data_n = tx_data;
        buf_full_n = 1'b1;
      end
    end
    if (use_fill) underrun_n = 1'b1;

    miso_n = (state_n == ACTIVE) ? tx_shift_n[DATA_W-1] : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      word_done <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      miso      <= 1'b1;
      miso_oe   <= 1'b0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      word_done <= word_done_n;
      tx_shift  <= tx_shift_n;
      rx_shift  <= rx_shift_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      miso      <= miso_n;
      miso_oe   <= miso_oe_n;
      buf_data  <= buf_data_n;
      buf_full  <= buf_full_n;
      underrun  <= underrun_n;
    end
  end

  assign busy     = (state == ACTIVE);
  assign tx_ready = ~buf_full;

endmodule
